imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 49 ++++
 tb/tb_imem_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin instruction-fetch arbiter for 4 requesters (clk, rst_n, req/req_addr/core_en in; gnt/stall out; mem_en/mem_addr/mem_rdata memory port; rvalid/rdata return; cnt_sel/cnt_clr/gnt_cnt grant counters)
module imem_arbiter #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [16*N-1:0] req_addr,
  input  logic [N-1:0]    core_en,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    stall,
  output logic            mem_en,
  output logic [15:0]     mem_addr,
  input  logic [15:0]     mem_rdata,
  output logic [N-1:0]    rvalid,
  output logic [15:0]     rdata,
  input  logic [1:0]      cnt_sel,
  input  logic            cnt_clr,
  output logic [15:0]     gnt_cnt
);
  logic [1:0]   ptr, gidx;
  logic [N-1:0] elig, rv_q;
  logic [15:0]  cnt [N];
  always_comb begin
    elig = rst_n ? req & core_en : '0;
    gidx = ptr;
    for (int k = N - 1; k >= 0; k--) if (elig[ptr + 2'(k)]) gidx = ptr + 2'(k);
    gnt = '0;
    gnt[gidx] = |elig;
    stall = elig & ~gnt;
    mem_en = |gnt;
    mem_addr = mem_en ? req_addr[16*gidx +: 16] : '0;
    rvalid = rv_q & core_en;
    rdata = |rvalid ? mem_rdata : '0;
    gnt_cnt = cnt[cnt_sel];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      rv_q <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      if (mem_en) ptr <= gidx + 2'd1;
      rv_q <= gnt;
      for (int i = 0; i < N; i++)
        cnt[i] <= cnt_clr ? '0 : (gnt[i] && cnt[i] != 16'hFFFF) ? cnt[i] + 16'd1 : cnt[i];
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
  logic        clk = 0, rst_n = 0, cnt_clr = 0, mem_en;
  logic [3:0]  req = 0, core_en = 0, gnt, stall, rvalid;
  logic [63:0] req_addr = 0;
  logic [15:0] mem_addr, mem_rdata = 0, rdata, gnt_cnt;
  logic [1:0]  cnt_sel = 0;
  int errors = 0, checks = 0;

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .core_en(core_en),
    .gnt(gnt), .stall(stall), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rvalid(rvalid), .rdata(rdata), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .gnt_cnt(gnt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_rdata <= mem_addr ^ 16'hA5A5;

  task automatic do_reset();
    @(negedge clk); rst_n = 0; req = 0; cnt_clr = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 0; req = 4'hF; core_en = 4'hF; req_addr = 64'h4444_3333_2222_1111;
    #1;
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
    checks++; if (stall !== 4'h0) begin errors++; $display("FAIL reset_stall got=%h exp=0", stall); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem got=%b/%h exp=0/0", mem_en, mem_addr); end
    checks++; if (rvalid !== 4'h0 || rdata !== 16'h0) begin errors++; $display("FAIL reset_ret got=%h/%h exp=0/0", rvalid, rdata); end
    checks++; if (gnt_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", gnt_cnt); end
    @(negedge clk); rst_n = 1; req = 0;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); req = 4'b0001; req_addr = 64'h0000_0000_0000_0010; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt[%0d] got=%b exp=0001", c, gnt); end
      checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0010) begin errors++; $display("FAIL single_addr[%0d] got=%b/%h exp=1/0010", c, mem_en, mem_addr); end
      checks++; if (stall !== 4'h0) begin errors++; $display("FAIL single_stall[%0d] got=%b exp=0000", c, stall); end
      if (c > 0) begin
        checks++; if (rvalid !== 4'b0001 || rdata !== 16'hA5B5) begin errors++; $display("FAIL single_ret[%0d] got=%b/%h exp=0001/a5b5", c, rvalid, rdata); end
      end
    end
    @(negedge clk); req = 0; #1;
    checks++; if (rvalid !== 4'b0001 || rdata !== 16'hA5B5 || gnt !== 4'h0) begin errors++; $display("FAIL single_tail got=%b/%h/%b exp=0001/a5b5/0000", rvalid, rdata, gnt); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 4'h0 || rdata !== 16'h0) begin errors++; $display("FAIL single_idle got=%b/%h exp=0000/0000", rvalid, rdata); end
  endtask

  task automatic test_contention();
    logic [3:0] eg, pg;
    logic [15:0] ea, pa;
    do_reset();
    req_addr = 64'h0340_0240_0140_0040;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); req = 4'hF; core_en = 4'hF; #1;
      eg = 4'b0001 << (c % 4);
      ea = 16'h0040 + 16'(16'h0100 * (c % 4));
      checks++; if (gnt !== eg) begin errors++; $display("FAIL cont_gnt[%0d] got=%b exp=%b", c, gnt, eg); end
      checks++; if (stall !== ~eg) begin errors++; $display("FAIL cont_stall[%0d] got=%b exp=%b", c, stall, ~eg); end
      checks++; if (mem_addr !== ea) begin errors++; $display("FAIL cont_addr[%0d] got=%h exp=%h", c, mem_addr, ea); end
      if (c > 0) begin
        checks++; if (rvalid !== pg || rdata !== (pa ^ 16'hA5A5)) begin errors++; $display("FAIL cont_ret[%0d] got=%b/%h exp=%b/%h", c, rvalid, rdata, pg, pa ^ 16'hA5A5); end
      end
      pg = eg; pa = ea;
    end
    @(negedge clk); req = 0;
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i); #1;
      checks++; if (gnt_cnt !== 16'd2) begin errors++; $display("FAIL cont_cnt[%0d] got=%0d exp=2", i, gnt_cnt); end
    end
  endtask

  task automatic test_mask();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); req = 4'b1010; core_en = 4'b1000; #1;
      checks++; if (gnt !== 4'b1000 || stall !== 4'b0000) begin errors++; $display("FAIL mask[%0d] got=%b/%b exp=1000/0000", c, gnt, stall); end
    end
    @(negedge clk); req = 0; core_en = 4'hF;
  endtask

  task automatic test_drop();
    @(negedge clk); req = 4'b0100; core_en = 4'hF; #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL drop_gnt got=%b exp=0100", gnt); end
    @(negedge clk); req = 0; core_en = 4'b1011; #1;
    checks++; if (rvalid !== 4'h0 || rdata !== 16'h0) begin errors++; $display("FAIL drop_ret got=%b/%h exp=0000/0000", rvalid, rdata); end
    @(negedge clk); core_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); req = 4'hF; core_en = 4'hF;
    end
    @(negedge clk); rst_n = 0; #1;
    checks++; if (gnt !== 4'h0 || stall !== 4'h0 || mem_en !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL mid_out got=%b/%b/%b/%h exp=0", gnt, stall, mem_en, mem_addr); end
    checks++; if (rvalid !== 4'h0 || rdata !== 16'h0) begin errors++; $display("FAIL mid_ret got=%b/%h exp=0000/0000", rvalid, rdata); end
    @(negedge clk); rst_n = 1; #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_first got=%b exp=0001", gnt); end
    checks++; if (rvalid !== 4'h0) begin errors++; $display("FAIL mid_inflight got=%b exp=0000", rvalid); end
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i); #1;
      checks++; if (gnt_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt[%0d] got=%0d exp=0", i, gnt_cnt); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk); req = 4'b0010; core_en = 4'hF; cnt_sel = 2'd1;
    repeat (65535) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (gnt_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_full got=%h exp=ffff", gnt_cnt); end
    @(negedge clk); #1;
    checks++; if (gnt_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", gnt_cnt); end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL sat_gnt got=%b exp=0010", gnt); end
    cnt_clr = 1;
    @(negedge clk); cnt_clr = 0; #1;
    checks++; if (gnt_cnt !== 16'h0) begin errors++; $display("FAIL sat_clr got=%h exp=0000", gnt_cnt); end
    @(negedge clk); #1;
    checks++; if (gnt_cnt !== 16'd1) begin errors++; $display("FAIL sat_after got=%h exp=0001", gnt_cnt); end
    req = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_mask();
    test_drop();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
